lab4_dma_reader: RTL and testbench
==================================

Name: lab4_dma_reader

Overview:
- Wishbone classic master that drains digitized LAB4D sample RAM through the DMA slave port of the parallel LAB4 RAM block.
- Walks the enabled channels and the requested word range of each, then streams the 32-bit words into a valid/ready output toward the SPI data-path packetizer.
- Sits directly downstream of the LAB4 RAM readout; started once per event after readout completes.

Parameters:
- NUM_LAB4, 24, number of channels walked (channel index 0..NUM_LAB4-1).
- CH_STRIDE, 2048, byte stride between channel windows in the DMA address space.
- FIFO_DEPTH, 4, output buffer entries (power of two, minimum 2).
- TIMEOUT, 255, clk_i cycles without ack/err/rty before a transfer aborts.

Ports:
- clk_i  in  1  Wishbone/system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- ch_mask_i  in  NUM_LAB4  channel enable, sampled on start.
- nwords_i  in  10  words per channel (0..512), sampled on start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of event (normal or abort).
- err_o  out  1  sticky abort flag; cleared by the next accepted start.
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe.
- wb_we_o  out  1  tied 0.
- wb_adr_o  out  16  byte address.
- wb_sel_o  out  4  tied 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1  termination.
- m_tdata_o  out  32  stream data.
- m_tvalid_o, m_tlast_o  out  1  stream valid / last word of event.
- m_tready_i  in  1  stream ready.

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; err_o 0.
- Address = ch*CH_STRIDE + word*4, computed in 16 bits; NUM_LAB4*CH_STRIDE must not exceed 65536.
- FSM states:
  - IDLE: on start_i, latch mask and nwords, clear err_o, ch=0, word=0 -> SCAN.
  - SCAN: if ch==NUM_LAB4 -> DONE. If channel disabled or nwords==0, ch++ (one channel per cycle). Else -> REQ.
  - REQ: wait until FIFO count < FIFO_DEPTH, so a completing read always has a slot. Then assert cyc/stb with a stable address -> WAIT.
  - WAIT: cyc/stb held.
    - ack: write wb_dat_i into the FIFO in the same cycle; drop cyc/stb next cycle. If word==nwords-1: word=0, ch++ -> SCAN; else word++ -> REQ.
    - rty: drop stb one cycle, reissue the same address.
    - err or timeout: set err_o, drop cyc/stb -> DONE.
  - DONE: pulse done_o, busy_o low next cycle -> IDLE.
- At least one idle cycle between strobes; at most one outstanding transfer.
- tlast: set on the FIFO entry of the final word of the last enabled nonzero channel. On abort, no further words are enqueued; words already buffered still drain, and the last one is marked tlast if not yet marked. If nothing was enqueued, no stream output occurs.
- Simultaneous ack and err: ack wins.
- FIFO is first-word-fall-through: data is valid the cycle after the write. Simultaneous push and pop at full is allowed.
- Stream: tdata/tlast stable while tvalid=1 and tready=0; tvalid never drops without a handshake.
- Reset mid-transfer drops cyc immediately (asynchronous) and discards FIFO contents.

Optional Feature:
- LAB4_DMA_HEADER_EN.
- When defined: before the first data word of each enabled nonzero channel, a header word {8'hA5, 3'b0, ch[4:0], 6'b0, nwords[9:0]} is enqueued in SCAN without a bus cycle. It waits for a FIFO slot like REQ.
- When undefined: data words only, no header logic.

Decomposition:
- Package lab4_dma_pkg: FSM state enum, header magic 8'hA5, header bit positions, NWORDS_W=10.
- One sub-module: lab4_dma_fifo (FWFT, parameter depth, count output, tlast bit carried with data).
- Address generation and FSM stay in the top module.

Test Plan:
- Mask 24'h000001, nwords=4, slave acks with 2-cycle latency, data = address: addresses 0x0000, 0x0004, 0x0008, 0x000C; stream 0,4,8,C; tlast on 0xC; one done_o pulse.
- Mask 24'h800002, nwords=2, tready=1: addresses 0x0800, 0x0804, 0xB800, 0xB804; tlast only on 0xB804.
- tready=0 for 20 cycles, nwords=8: exactly 4 reads complete, no strobe while FIFO is full, all 8 words arrive in order after release.
- rty on the first attempt at 0x0004, then ack: 0x0004 reissued once, no duplicate word. err on the 3rd read: err_o=1, 2 words streamed, the second with tlast, done_o pulses.
- No ack for 256 cycles: err_o=1, cyc drops, done_o pulses. start_i while busy is ignored. nwords=0 or mask=0: done_o within NUM_LAB4+3 cycles, no bus traffic.
- With LAB4_DMA_HEADER_EN, mask 24'h000004, nwords=3: stream 0xA5020003, then 0x1000, 0x1004, 0x1008 (tlast).

Source files
------------

// File: rtl/lab4_dma_pkg.sv
// rtl/lab4_dma_pkg.sv - shared types and header layout for the LAB4 DMA reader
// Header layout is used only when LAB4_DMA_HEADER_EN is defined.
package lab4_dma_pkg;

  localparam int NWORDS_W      = 10;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CH_LSB    = 16;
  localparam int HDR_NW_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_WAIT,
    ST_RETRY,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  function automatic logic [31:0] hdr_word(input logic [4:0] ch, input logic [NWORDS_W-1:0] nw);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 8]   = HDR_MAGIC;
    w[HDR_CH_LSB +: 5]      = ch;
    w[HDR_NW_LSB +: NWORDS_W] = nw;
    return w;
  endfunction

endpackage

// File: rtl/lab4_dma_fifo.sv
// rtl/lab4_dma_fifo.sv - first-word-fall-through output buffer carrying tlast with data
// mark_last_i retro-tags the newest buffered entry as last (used when an event aborts).
module lab4_dma_fifo
  import lab4_dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [31:0]                  push_data_i,
  input  logic                         push_last_i,
  input  logic                         mark_last_i,
  input  logic                         pop_i,
  output logic [31:0]                  data_o,
  output logic                         last_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d, tail;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tail    = wr_q - 1'b1;
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    if (mark_last_i && (cnt_q != '0)) mem_d[tail].last = 1'b1;
    if (do_push) begin
      mem_d[wr_q] = {push_last_i, push_data_i};
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // A mark arriving while the sole entry is at the head must show immediately.
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q].data;
  assign last_o  = mem_q[rd_q].last | (mark_last_i && (cnt_q == CW'(1)));
  assign count_o = cnt_q;

endmodule

// File: rtl/lab4_dma_reader.sv
// rtl/lab4_dma_reader.sv - Wishbone master draining LAB4 sample RAM into a valid/ready stream
// Optional per-channel header word enabled by LAB4_DMA_HEADER_EN.
module lab4_dma_reader
  import lab4_dma_pkg::*;
#(
  parameter int NUM_LAB4   = 24,
  parameter int CH_STRIDE  = 2048,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [NUM_LAB4-1:0]   ch_mask_i,
  input  logic [NWORDS_W-1:0]   nwords_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [15:0]           wb_adr_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  output logic [31:0]           m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  input  logic                  m_tready_i
);

  localparam int CH_W  = $clog2(NUM_LAB4+1);
  localparam int TMO_W = $clog2(TIMEOUT+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [NWORDS_W-1:0]   word_q, word_d, nw_q, nw_d;
  logic [NUM_LAB4-1:0]   mask_q, mask_d, hi_mask;
  logic                  err_q, err_d, cyc_q, cyc_d, stb_q, stb_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  push, push_last, mark_last, room, last_ch, last_word;
  logic [31:0]           push_data;
  logic [CNT_W-1:0]      fifo_count;
`ifdef LAB4_DMA_HEADER_EN
  logic                  hdr_q, hdr_d;
`endif

  assign room      = fifo_count < CNT_W'(FIFO_DEPTH);
  assign hi_mask   = mask_q >> (32'(ch_q) + 32'd1);
  assign last_ch   = (hi_mask == '0);
  assign last_word = (word_q == nw_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    word_d    = word_q;
    mask_d    = mask_q;
    nw_d      = nw_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    push_data = wb_dat_i;
    push_last = 1'b0;
    mark_last = 1'b0;
`ifdef LAB4_DMA_HEADER_EN
    hdr_d     = hdr_q;
`endif
    case (state_q)
      ST_IDLE: if (start_i) begin
        mask_d  = ch_mask_i;
        nw_d    = nwords_i;
        err_d   = 1'b0;
        ch_d    = '0;
        word_d  = '0;
`ifdef LAB4_DMA_HEADER_EN
        hdr_d   = 1'b0;
`endif
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (ch_q == CH_W'(NUM_LAB4)) state_d = ST_DONE;
        else if (!mask_q[ch_q] || (nw_q == '0)) ch_d = ch_q + 1'b1;
        else begin
`ifdef LAB4_DMA_HEADER_EN
          if (!hdr_q) begin
            if (room) begin
              push      = 1'b1;
              push_data = hdr_word(5'(ch_q), nw_q);
              hdr_d     = 1'b1;
            end
          end else state_d = ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: if (room) begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wb_ack_i) begin
          push      = 1'b1;
          push_last = last_word && last_ch;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          if (last_word) begin
            word_d  = '0;
            ch_d    = ch_q + 1'b1;
`ifdef LAB4_DMA_HEADER_EN
            hdr_d   = 1'b0;
`endif
            state_d = ST_SCAN;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = ST_REQ;
          end
        end else if (wb_err_i || (!wb_rty_i && (tmo_q == TMO_W'(TIMEOUT-1)))) begin
          err_d     = 1'b1;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          mark_last = 1'b1;
          state_d   = ST_DONE;
        end else if (wb_rty_i) begin
          stb_d   = 1'b0;
          state_d = ST_RETRY;
        end else tmo_d = tmo_q + 1'b1;
      end
      // cyc stays asserted across the one-cycle strobe gap of a retry.
      ST_RETRY: begin
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      nw_q    <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      tmo_q   <= '0;
`ifdef LAB4_DMA_HEADER_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      nw_q    <= nw_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      tmo_q   <= tmo_d;
`ifdef LAB4_DMA_HEADER_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  lab4_dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i (push_data),
    .push_last_i (push_last),
    .mark_last_i (mark_last),
    .pop_i       (m_tvalid_o && m_tready_i),
    .data_o      (m_tdata_o),
    .last_o      (m_tlast_o),
    .valid_o     (m_tvalid_o),
    .count_o     (fifo_count)
  );

  assign wb_adr_o = 16'(32'(ch_q) * 32'(CH_STRIDE)) + 16'({word_q, 2'b00});
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign err_o    = err_q;

endmodule

// File: tb/tb_lab4_dma_reader.sv
// tb/tb_lab4_dma_reader.sv - directed bench for lab4_dma_reader with Wishbone slave and stream sink
module tb_lab4_dma_reader;

`ifdef LAB4_DMA_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [23:0] ch_mask = '0;
  logic [9:0]  nwords = '0;
  logic        busy, done, err, cyc, stb, we;
  logic [15:0] adr;
  logic [3:0]  sel;
  logic [31:0] wb_dat = '0;
  logic        ack = 1'b0, wberr = 1'b0, rty = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b0;

  always #5 clk = ~clk;

  lab4_dma_reader dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .ch_mask_i(ch_mask), .nwords_i(nwords),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_sel_o(sel),
    .wb_dat_i(wb_dat), .wb_ack_i(ack), .wb_err_i(wberr), .wb_rty_i(rty),
    .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tlast_o(tlast), .m_tready_i(tready)
  );

  int errors = 0, checks = 0;
  int lat = 1, rty_adr = -1, err_at = -1;
  bit no_ack = 1'b0, clr = 1'b0;

  logic [15:0] adr_log[$];
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          ack_cnt = 0, done_cnt = 0, stab_err = 0, rd_cnt = 0, wcnt = 0;
  bit          rty_used = 1'b0, stb_seen = 1'b0, hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [15:0] exp_a[$];

  // Slave responds and sink samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    ack = 1'b0; wberr = 1'b0; rty = 1'b0;
    if (clr) begin
      adr_log.delete(); got_d.delete(); got_l.delete();
      ack_cnt = 0; done_cnt = 0; stab_err = 0; rd_cnt = 0; wcnt = 0;
      rty_used = 1'b0; stb_seen = 1'b0; hold_v = 1'b0;
    end else begin
      if (cyc && stb) begin
        if (!stb_seen) begin adr_log.push_back(adr); stb_seen = 1'b1; wcnt = 0; end
        wcnt++;
        if (!no_ack && wcnt >= lat) begin
          if (int'(adr) == rty_adr && !rty_used) begin rty = 1'b1; rty_used = 1'b1; end
          else if (rd_cnt == err_at) begin wberr = 1'b1; rd_cnt++; end
          else begin ack = 1'b1; wb_dat = {16'h0, adr}; rd_cnt++; ack_cnt++; end
        end
      end else stb_seen = 1'b0;
      if (hold_v && (!tvalid || tdata !== hold_d || tlast !== hold_l)) stab_err++;
      hold_v = tvalid && !tready; hold_d = tdata; hold_l = tlast;
      if (tvalid && tready) begin got_d.push_back(tdata); got_l.push_back(tlast); end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic exp_word(input logic [31:0] d, input logic l);
    exp_d.push_back(d); exp_l.push_back(l);
  endtask

  task automatic exp_hdr(input logic [4:0] ch, input logic [9:0] nw, input logic l);
    if (HDR_EN) exp_word({8'hA5, 3'b0, ch, 6'b0, nw}, l);
  endtask

  task automatic clear_logs();
    exp_d.delete(); exp_l.delete(); exp_a.delete();
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic start_event(input logic [23:0] m, input logic [9:0] n);
    @(posedge clk); #1;
    ch_mask = m; nwords = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (done_cnt == 0 && c < budget) begin @(posedge clk); c++; end
    #1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " words"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        check($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
        check($sformatf("%s last[%0d]", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
      end
    end
  endtask

  task automatic compare_adrs(input string tag);
    check({tag, " strobes"}, adr_log.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < adr_log.size()) check($sformatf("%s adr[%0d]", tag, i), 32'(adr_log[i]), 32'(exp_a[i]));
    end
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst cyc", cyc, 0);
    check("rst stb", stb, 0);
    check("rst adr", adr, 0);
    check("rst tvalid", tvalid, 0);
    check("rst tdata", tdata, 0);
    rst_n = 1'b1;

    // single channel, 2-cycle slave latency
    clear_logs(); lat = 2; tready = 1'b1;
    start_event(24'h000001, 10'd4);
    check("t1 busy", busy, 1);
    wait_done(200, c);
    repeat (8) @(posedge clk); #1;
    check("t1 done", done_cnt, 1);
    check("t1 idle", busy, 0);
    check("t1 err", err, 0);
    for (int i = 0; i < 4; i++) exp_a.push_back(16'(i * 4));
    compare_adrs("t1");
    exp_hdr(5'd0, 10'd4, 1'b0);
    for (int i = 0; i < 4; i++) exp_word(32'(i * 4), i == 3);
    compare_stream("t1");

    // first and last channel
    clear_logs(); lat = 1;
    start_event(24'h800002, 10'd2);
    wait_done(200, c);
    repeat (8) @(posedge clk); #1;
    check("t2 done", done_cnt, 1);
    exp_a.push_back(16'h0800); exp_a.push_back(16'h0804);
    exp_a.push_back(16'hB800); exp_a.push_back(16'hB804);
    compare_adrs("t2");
    exp_hdr(5'd1, 10'd2, 1'b0);
    exp_word(32'h0800, 1'b0); exp_word(32'h0804, 1'b0);
    exp_hdr(5'd23, 10'd2, 1'b0);
    exp_word(32'hB800, 1'b0); exp_word(32'hB804, 1'b1);
    compare_stream("t2");

    // backpressure: the buffer fills and the master stops strobing
    clear_logs(); tready = 1'b0;
    start_event(24'h000001, 10'd8);
    repeat (20) @(posedge clk); #1;
    check("t3 acks while stalled", ack_cnt, HDR_EN ? 3 : 4);
    check("t3 strobes while stalled", adr_log.size(), HDR_EN ? 3 : 4);
    check("t3 stalled tvalid", tvalid, 1);
    check("t3 busy", busy, 1);
    tready = 1'b1;
    wait_done(300, c);
    repeat (8) @(posedge clk); #1;
    check("t3 done", done_cnt, 1);
    check("t3 stability", stab_err, 0);
    exp_hdr(5'd0, 10'd8, 1'b0);
    for (int i = 0; i < 8; i++) exp_word(32'(i * 4), i == 7);
    compare_stream("t3");

    // retry on 0x0004, then bus error on the third read
    clear_logs(); tready = 1'b0; rty_adr = 4; err_at = 2;
    start_event(24'h000001, 10'd4);
    wait_done(200, c);
    repeat (2) @(posedge clk); #1;
    check("t4 err", err, 1);
    check("t4 cyc", cyc, 0);
    exp_a.push_back(16'h0000); exp_a.push_back(16'h0004);
    exp_a.push_back(16'h0004); exp_a.push_back(16'h0008);
    compare_adrs("t4");
    tready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("t4 done", done_cnt, 1);
    exp_hdr(5'd0, 10'd4, 1'b0);
    exp_word(32'h0000, 1'b0); exp_word(32'h0004, 1'b1);
    compare_stream("t4");
    rty_adr = -1; err_at = -1;

    // silent slave: timeout abort; a start while busy is ignored
    clear_logs(); no_ack = 1'b1;
    start_event(24'h000001, 10'd2);
    repeat (100) @(posedge clk); #1;
    start = 1'b1; ch_mask = 24'hFFFFFF; nwords = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk); #1;
    check("t5 cyc held", cyc, 1);
    check("t5 stb held", stb, 1);
    wait_done(200, c);
    repeat (4) @(posedge clk); #1;
    check("t5 err", err, 1);
    check("t5 cyc dropped", cyc, 0);
    check("t5 done", done_cnt, 1);
    check("t5 idle", busy, 0);
    exp_a.push_back(16'h0000);
    compare_adrs("t5");
    exp_hdr(5'd0, 10'd2, 1'b0);
    compare_stream("t5");
    no_ack = 1'b0;

    // nwords=0 and mask=0 finish quickly with no bus traffic
    clear_logs();
    start_event(24'hFFFFFF, 10'd0);
    check("t6 err cleared", err, 0);
    wait_done(40, c);
    check("t6 latency ok", 32'(c <= 27), 1);
    repeat (4) @(posedge clk); #1;
    check("t6 done", done_cnt, 1);
    check("t6 strobes", adr_log.size(), 0);
    check("t6 words", got_d.size(), 0);

    clear_logs();
    start_event(24'h000000, 10'd5);
    wait_done(40, c);
    check("t7 latency ok", 32'(c <= 27), 1);
    repeat (4) @(posedge clk); #1;
    check("t7 done", done_cnt, 1);
    check("t7 strobes", adr_log.size(), 0);
    check("t7 words", got_d.size(), 0);

    // channel 2, three words (header-prefixed when enabled)
    clear_logs();
    start_event(24'h000004, 10'd3);
    wait_done(200, c);
    repeat (8) @(posedge clk); #1;
    check("t8 done", done_cnt, 1);
    exp_hdr(5'd2, 10'd3, 1'b0);
    exp_word(32'h1000, 1'b0); exp_word(32'h1004, 1'b0); exp_word(32'h1008, 1'b1);
    compare_stream("t8");

    // asynchronous reset in the middle of a transfer
    clear_logs(); no_ack = 1'b1;
    start_event(24'h000001, 10'd1);
    repeat (5) @(posedge clk); #1;
    check("t9 cyc before reset", cyc, 1);
    rst_n = 1'b0;
    #1;
    check("t9 cyc after reset", cyc, 0);
    check("t9 stb after reset", stb, 0);
    check("t9 busy after reset", busy, 0);
    check("t9 tvalid after reset", tvalid, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; no_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
